// File: rtl/gray_monitor.sv
// Gray-code counter health monitor: converts each enabled sample to binary, checks single-step legality,
// counts laps and latches faults. Define GRAY_MON_DIR_EN to also accept backward steps and expose Dir.
module gray_monitor #(
    parameter int LAP_W = 8,
    parameter int ERR_W = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             En,
    input  logic [2:0]       Gray,
    input  logic             Clr,
    output logic [2:0]       Bin,
    output logic             Valid,
    output logic [LAP_W-1:0] Laps,
    output logic             Err,
`ifdef GRAY_MON_DIR_EN
    output logic             Dir,
`endif
    output logic [ERR_W-1:0] ErrCnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t           r_state;
    logic [2:0]       r_prev;
    logic [2:0]       r_bin;
    logic             r_valid;
    logic [LAP_W-1:0] r_laps;
    logic             r_err;
    logic [ERR_W-1:0] r_errCnt;
`ifdef GRAY_MON_DIR_EN
    logic             r_dir;
`endif

    function automatic logic [2:0] g2b(input logic [2:0] g);
        logic [2:0] b;
        b[2] = g[2];
        b[1] = g[2] ^ g[1];
        b[0] = b[1] ^ g[0];
        return b;
    endfunction

    logic [2:0] w_b;
    logic [2:0] w_pb;
    logic [2:0] w_pbNext;
    logic [2:0] w_pbPrev;
    logic       w_stall;
    logic       w_fwd;
    logic       w_bwd;

    assign w_b      = g2b(Gray);
    assign w_pb     = g2b(r_prev);
    assign w_pbNext = w_pb + 3'd1;
    assign w_pbPrev = w_pb - 3'd1;
    assign w_stall  = (Gray == r_prev);
    assign w_fwd    = (w_b == w_pbNext);
    assign w_bwd    = (w_b == w_pbPrev);

    // Clr outranks En so a sample arriving with Clr is dropped; a faulting step keeps the last good Bin/prev.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state  <= IDLE;
            r_prev   <= 3'd0;
            r_bin    <= 3'd0;
            r_valid  <= 1'b0;
            r_laps   <= '0;
            r_err    <= 1'b0;
            r_errCnt <= '0;
`ifdef GRAY_MON_DIR_EN
            r_dir    <= 1'b0;
`endif
        end else if (Clr) begin
            r_state <= IDLE;
            r_err   <= 1'b0;
            r_valid <= 1'b0;
        end else if (En) begin
            case (r_state)
                IDLE: begin
                    r_prev  <= Gray;
                    r_bin   <= w_b;
                    r_valid <= 1'b1;
                    r_state <= TRACK;
                end
                TRACK: begin
                    if (w_stall) begin
                        r_state <= TRACK;
                    end else if (w_fwd) begin
                        r_bin  <= w_b;
                        r_prev <= Gray;
`ifdef GRAY_MON_DIR_EN
                        r_dir  <= 1'b0;
`endif
                        if (w_pb == 3'd7 && r_laps != '1)
                            r_laps <= r_laps + LAP_W'(1);
                    end
`ifdef GRAY_MON_DIR_EN
                    else if (w_bwd) begin
                        r_bin  <= w_b;
                        r_prev <= Gray;
                        r_dir  <= 1'b1;
                        if (w_pb == 3'd0 && r_laps != '0)
                            r_laps <= r_laps - LAP_W'(1);
                    end
`endif
                    else begin
                        r_err   <= 1'b1;
                        r_state <= FAULT;
                        if (r_errCnt != '1)
                            r_errCnt <= r_errCnt + ERR_W'(1);
                    end
                end
                FAULT: begin
                    r_state <= FAULT;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign Bin    = r_bin;
    assign Valid  = r_valid;
    assign Laps   = r_laps;
    assign Err    = r_err;
    assign ErrCnt = r_errCnt;
`ifdef GRAY_MON_DIR_EN
    assign Dir    = r_dir;
`endif

`ifndef GRAY_MON_DIR_EN
    logic w_unusedBwd;
    assign w_unusedBwd = w_bwd;
`endif

endmodule
